// File: rtl/mac_feeder.sv
// Sequences operand pairs into an external saturating MAC: clear, feed LEN pairs,
// let the pipeline drain, then hold the captured accumulator value until taken.
module mac_feeder #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned DRAIN = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        mac_clr,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    input  logic [15:0] mac_s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FEED, ST_DRAIN, ST_HOLD} state_t;

    localparam logic [7:0] LAST_PAIR = 8'(LEN - 1);
    localparam logic [3:0] DRAIN_LD  = 4'(DRAIN);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  drn_q, drn_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic        clr_q, clr_d;
    logic [15:0] res_q, res_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            clr_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clr_q   <= clr_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        a_d     = 8'd0;
        b_d     = 8'd0;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED: begin
                // Idle FEED cycles present a zero operand so gaps add nothing
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_PAIR) begin
                        state_d = ST_DRAIN;
                        drn_d   = DRAIN_LD;
                    end
                end
            end
            ST_DRAIN: begin
                // First DRAIN cycle still presents the last pair, so DRAIN+1 cycles here
                if (drn_q == 4'd0) begin
                    res_d   = mac_s;
                    state_d = ST_HOLD;
                end else begin
                    drn_d = drn_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        clr_d = (state_d == ST_CLEAR);
    end

    assign in_ready  = (state_q == ST_FEED);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign mac_clr   = clr_q;
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign out_data  = res_q;
endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter LEN, default 4: number of operand pairs per dot product; legal range 1..255.
REQ-002 Parameter DRAIN, default 4: idle cycles between the last issued pair and result capture; legal range 1..15.
REQ-003 clock  input  1: single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: upstream operand pair valid.
REQ-006 in_ready  output  1: block accepts an operand pair this cycle.
REQ-007 in_a  input  8: unsigned operand A.
REQ-008 in_b  input  8: unsigned operand B.
REQ-009 mac_clr  output  1: active-high clear to the downstream MAC accumulator.
REQ-010 mac_a  output  8: registered operand A to the MAC.
REQ-011 mac_b  output  8: registered operand B to the MAC.
REQ-012 mac_s  input  16: saturated accumulator value returned by the MAC.
REQ-013 out_valid  output  1: result valid.
REQ-014 out_ready  input  1: downstream accepts the result.
REQ-015 out_data  output  16: captured dot-product result.
REQ-016 busy  output  1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and HOLD.
REQ-018 IDLE: in_ready=0; mac_a=mac_b=0; the FSM moves to CLEAR on the first cycle in_valid=1, and that pair is not consumed.
REQ-019 CLEAR: lasts exactly 1 cycle; mac_clr=1 only while the FSM is in CLEAR; in_ready=0; the next state is FEED.
REQ-020 mac_clr SHALL be a registered output, glitch-free, and 0 in every other state.
REQ-021 FEED: in_ready=1; a transfer occurs on in_valid&in_ready.
REQ-022 On a transfer, mac_a<=in_a, mac_b<=in_b and the 8-bit pair count increments.
REQ-023 On a FEED cycle without a transfer, mac_a<=0 and mac_b<=0, so the product contributed is zero; gaps in in_valid are legal and do not alter the result.
REQ-024 When the LEN-th transfer occurs, the FSM SHALL enter DRAIN on the next edge, with in_ready=0 from that edge onward; no more than LEN pairs are accepted per dot product.
REQ-025 DRAIN: mac_a=mac_b=0 for exactly DRAIN cycles, counted by a 4-bit down-counter.
REQ-026 On the final DRAIN cycle, out_data<=mac_s and the FSM enters HOLD.
REQ-027 HOLD: out_valid=1 and out_data stays stable until out_ready=1.
REQ-028 On out_valid&out_ready, the FSM SHALL return to IDLE with out_valid=0 on the next edge.
REQ-029 out_ready while out_valid=0 SHALL be ignored.
REQ-030 Latency: the first FEED cycle is 2 cycles after in_valid rises in IDLE. out_valid rises DRAIN+1 cycles after the LEN-th transfer edge.
REQ-031 A new in_valid during HOLD SHALL not be accepted (in_ready=0); it is serviced after the return to IDLE.
REQ-032 The block SHALL perform no arithmetic on mac_s; saturation is owned by the MAC.
REQ-033 out_data SHALL equal mac_s bit-exact, including 16'hFFFF.
REQ-034 The pair counter SHALL reset to 0 on every entry to CLEAR; no counter may wrap.

Reset
REQ-035 While reset_n=0, asynchronously: state=IDLE, in_ready=0, mac_clr=0, mac_a=0, mac_b=0, out_valid=0, out_data=0, busy=0, all counters=0.
REQ-036 Reset asserted in any state, including mid-FEED or HOLD, SHALL abort the operation; any partial result is discarded.
REQ-037 After reset deasserts, the block SHALL wait in IDLE and issue a fresh CLEAR before the next FEED.

Verification
REQ-038 Bench uses an ideal saturating accumulator model with result latency <= DRAIN and clear on mac_clr.
- LEN=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, out_ready=1 -> mac_clr pulses 1 cycle; out_data=16'd100; out_valid high 1 cycle.
- LEN=4, four pairs (255,255) -> out_data=16'hFFFF (true sum 260100 saturated).
- Same pairs as the first scenario with in_valid low 3 cycles between pairs 2 and 3 -> out_data=16'd100; mac_a=mac_b=0 during the gap.
- out_ready held low 5 cycles in HOLD -> out_valid and out_data=16'd100 stable; in_ready=0; IDLE one cycle after out_ready=1.
- reset_n pulsed low after 2 of 4 transfers, then a fresh 4-pair vector (2,3)x4 -> all outputs 0 during reset; next mac_clr precedes feed; out_data=16'd24.
- LEN=1, pair (16,16) -> out_data=16'd256; out_valid DRAIN+1 cycles after the transfer.
